diamond_collect_ctrl: RTL and testbench
=======================================

// Module: diamond_collect_ctrl
// PURPOSE
//  Per-frame collection controller for the three blue and three red diamonds on level 1.
//  - Generates the per-diamond eaten flags consumed by the diamond display logic.
//  - Once per frame, time-multiplexes one shared overlap checker across all six diamonds:
//    - blue diamonds are tested against watergirl;
//    - red diamonds are tested against fireboy.
//  - Keeps collected counts and raises level-complete status.
//  - Sits between the character motion blocks and the diamond display/colour mapper.
// PARAMETERS
//  PLAYER_W       20  character hitbox width, pixels
//  PLAYER_H       30  character hitbox height, pixels
//  SPARKLE_FRAMES 8   frames a collected diamond blinks before hiding (DIAMOND_SPARKLE_EN only), 1..15
// PORTS
//  Clk                 in   1   system clock
//  Reset               in   1   synchronous, active-high reset
//  frame_start         in   1   one-cycle pulse per frame (vsync rising)
//  game_active         in   1   frame_start is ignored while low
//  level_restart       in   1   one-cycle pulse; clears all collection state
//  fb_x, fb_y          in   10  fireboy hitbox top-left
//  wg_x, wg_y          in   10  watergirl hitbox top-left
//  is_diamond_eat_blue out  3   [i]=1 hides blue diamond i
//  is_diamond_eat_red  out  3   [i]=1 hides red diamond i
//  blue_count          out  2   blue diamonds collected, 0..3
//  red_count           out  2   red diamonds collected, 0..3
//  all_collected       out  1   blue_count==3 && red_count==3
//  collect_pulse       out  1   one cycle per newly collected diamond
//  scan_busy           out  1   high while a scan is in progress
// BEHAVIOUR
//  Reset values: every output is 0; FSM is in IDLE; scan index is 0.
//  FSM: IDLE -> SCAN -> DONE -> IDLE.
//  - IDLE: on frame_start && game_active, latch fb_x/fb_y/wg_x/wg_y, clear the index, go to SCAN.
//  - SCAN: one diamond per cycle, indices 0..5.
//    - Indices 0-2 are blue 0-2, checked against latched watergirl.
//    - Indices 3-5 are red 0-2, checked against latched fireboy.
//    - After index 5, go to DONE.
//  - DONE: one cycle; update all_collected; go to IDLE.
//  Timing: frame_start at cycle T.
//  - Index i is evaluated in cycle T+1+i.
//  - A resulting flag, count or collect_pulse change is visible in T+2+i.
//  - all_collected is valid in T+8.
//  - scan_busy is high in T+1..T+7.
//  Overlap test: hit = px<dx+20 && px+PLAYER_W>dx && py<dy+20 && py+PLAYER_H>dy.
//  - All sums use 11-bit unsigned arithmetic, so there is no wrap.
//  - Edge-touching boxes do not hit.
//  A diamond already collected is skipped: no pulse and no count change. Counts saturate at 3.
//  frame_start while not in IDLE is dropped. It is not queued.
//  level_restart has the highest priority in any state.
//  - Next cycle: flags, counts, all_collected and sparkle timers are 0, and the FSM is in IDLE.
//  - A scan in progress is abandoned.
//  - A frame_start in the same cycle is dropped.
//  Position inputs may change freely during a scan; only the latched snapshot is used.
// CONFIGURATION
//  DIAMOND_SPARKLE_EN defined:
//  - On collection, load a 4-bit per-diamond timer with SPARKLE_FRAMES.
//  - While the timer is nonzero, the eat flag equals timer[1] (blink), and the timer
//    decrements on each accepted frame_start.
//  - When the timer is 0, the eat flag is 1.
//  - Counts, collect_pulse and all_collected update at collection, independent of blinking.
//  DIAMOND_SPARKLE_EN undefined: the eat flag equals the collected bit; no timers exist.
// STRUCTURE
//  Package diamond_pkg holds:
//  - DIAMOND_SIZE=20 and NUM_DIAMONDS=6.
//  - Coordinate constants:
//    - blue: (460,408), (366,238), (38,90);
//    - red: (330,408), (300,220), (190,42).
//  - The FSM state enum typedef {IDLE, SCAN, DONE}.
//  Sub-module diamond_hit_check: combinational 11-bit box-overlap comparator, one shared instance.
// TESTING
//  1. Reset; wg=(455,400); frame_start
//     -> is_diamond_eat_blue=3'b001 at T+2; blue_count=1; collect_pulse high one cycle at T+2.
//  2. fb=(350,408), touching red0 at the edge; frame_start
//     -> no hit; red flags stay 0.
//     Then fb=(349,408); frame_start -> red0 eaten at T+5.
//  3. Repeat the same hit over 3 frames -> blue_count stays 1; only one collect_pulse total.
//  4. Collect all six diamonds across frames -> all_collected=1 in DONE+1; counts=3/3.
//     Then level_restart -> all flags, counts and all_collected = 0 next cycle.
//  5. level_restart at T+3 mid-scan with a pending red hit -> no red flag set; FSM in IDLE.
//     A frame_start during SCAN is dropped: scan_busy is not re-extended.
//  6. DIAMOND_SPARKLE_EN, SPARKLE_FRAMES=8: collect blue1
//     -> flag follows timer[1] over the next 8 frames, then is constant 1.
//     blue_count=1 immediately.

Source files
------------

// File: rtl/diamond_pkg.sv
// ============================================================================
// Module  : diamond_pkg
// Brief   : Level-1 diamond geometry, counts and collection FSM state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package diamond_pkg;

    localparam int DIAMOND_SIZE = 20;
    localparam int NUM_DIAMONDS = 6;

    localparam logic [9:0] c_blue0_x = 10'd460;
    localparam logic [9:0] c_blue0_y = 10'd408;
    localparam logic [9:0] c_blue1_x = 10'd366;
    localparam logic [9:0] c_blue1_y = 10'd238;
    localparam logic [9:0] c_blue2_x = 10'd38;
    localparam logic [9:0] c_blue2_y = 10'd90;
    localparam logic [9:0] c_red0_x  = 10'd330;
    localparam logic [9:0] c_red0_y  = 10'd408;
    localparam logic [9:0] c_red1_x  = 10'd300;
    localparam logic [9:0] c_red1_y  = 10'd220;
    localparam logic [9:0] c_red2_x  = 10'd190;
    localparam logic [9:0] c_red2_y  = 10'd42;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Scan index 0..2 selects blue 0..2, 3..5 selects red 0..2.
    function automatic logic [9:0] diamond_x(input logic [2:0] idx);
        case (idx)
            3'd0:    return c_blue0_x;
            3'd1:    return c_blue1_x;
            3'd2:    return c_blue2_x;
            3'd3:    return c_red0_x;
            3'd4:    return c_red1_x;
            3'd5:    return c_red2_x;
            default: return 10'd0;
        endcase
    endfunction

    function automatic logic [9:0] diamond_y(input logic [2:0] idx);
        case (idx)
            3'd0:    return c_blue0_y;
            3'd1:    return c_blue1_y;
            3'd2:    return c_blue2_y;
            3'd3:    return c_red0_y;
            3'd4:    return c_red1_y;
            3'd5:    return c_red2_y;
            default: return 10'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/diamond_hit_check.sv
// ============================================================================
// Module  : diamond_hit_check
// Brief   : Combinational box-overlap test of a player hitbox against one diamond.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module diamond_hit_check
    import diamond_pkg::*;
#(
    parameter int PLAYER_W = 20,
    parameter int PLAYER_H = 30
) (
    input  logic [9:0] px,
    input  logic [9:0] py,
    input  logic [9:0] dx,
    input  logic [9:0] dy,
    output logic       hit
);

    // Widened to 11 bits so the sums below can never wrap.
    logic [10:0] w_px;
    logic [10:0] w_py;
    logic [10:0] w_dx;
    logic [10:0] w_dy;

    assign w_px = {1'b0, px};
    assign w_py = {1'b0, py};
    assign w_dx = {1'b0, dx};
    assign w_dy = {1'b0, dy};

    assign hit = (w_px < w_dx + 11'(DIAMOND_SIZE)) &&
                 (w_px + 11'(PLAYER_W) > w_dx) &&
                 (w_py < w_dy + 11'(DIAMOND_SIZE)) &&
                 (w_py + 11'(PLAYER_H) > w_dy);

endmodule

`default_nettype wire

// File: rtl/diamond_collect_ctrl.sv
// ============================================================================
// Module  : diamond_collect_ctrl
// Brief   : Per-frame diamond collection scan, eat flags, counts and level status.
//           Optional blink-before-hide behaviour under macro DIAMOND_SPARKLE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module diamond_collect_ctrl
    import diamond_pkg::*;
#(
    parameter int PLAYER_W = 20,
`ifdef DIAMOND_SPARKLE_EN
    parameter int SPARKLE_FRAMES = 8,
`endif
    parameter int PLAYER_H = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       game_active,
    input  logic       level_restart,
    input  logic [9:0] fb_x,
    input  logic [9:0] fb_y,
    input  logic [9:0] wg_x,
    input  logic [9:0] wg_y,
    output logic [2:0] is_diamond_eat_blue,
    output logic [2:0] is_diamond_eat_red,
    output logic [1:0] blue_count,
    output logic [1:0] red_count,
    output logic       all_collected,
    output logic       collect_pulse,
    output logic       scan_busy
);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_idx;
    logic [9:0]  r_fb_x, r_fb_y, r_wg_x, r_wg_y;
    logic [NUM_DIAMONDS-1:0] r_collected;
    logic [1:0]  r_blue_count, r_red_count;
    logic        r_all, r_pulse;

    logic        w_accept;
    logic        w_is_red;
    logic [9:0]  w_px, w_py, w_dx, w_dy;
    logic        w_hit;
    logic        w_new_hit;
    logic [NUM_DIAMONDS-1:0] w_eat;

    assign w_accept  = (r_state == IDLE) && frame_start && game_active && !level_restart;
    assign w_is_red  = (r_idx >= 3'd3);
    assign w_px      = w_is_red ? r_fb_x : r_wg_x;
    assign w_py      = w_is_red ? r_fb_y : r_wg_y;
    assign w_dx      = diamond_x(r_idx);
    assign w_dy      = diamond_y(r_idx);
    assign w_new_hit = (r_state == SCAN) && w_hit && !r_collected[r_idx];

    diamond_hit_check #(
        .PLAYER_W (PLAYER_W),
        .PLAYER_H (PLAYER_H)
    ) u_hit_check (
        .px  (w_px),
        .py  (w_py),
        .dx  (w_dx),
        .dy  (w_dy),
        .hit (w_hit)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = SCAN;
            SCAN:    if (r_idx == 3'd5) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (level_restart) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || level_restart) begin
            r_idx        <= 3'd0;
            r_fb_x       <= 10'd0;
            r_fb_y       <= 10'd0;
            r_wg_x       <= 10'd0;
            r_wg_y       <= 10'd0;
            r_collected  <= '0;
            r_blue_count <= 2'd0;
            r_red_count  <= 2'd0;
            r_all        <= 1'b0;
            r_pulse      <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_fb_x <= fb_x;
                        r_fb_y <= fb_y;
                        r_wg_x <= wg_x;
                        r_wg_y <= wg_y;
                        r_idx  <= 3'd0;
                    end
                end
                SCAN: begin
                    r_idx <= r_idx + 3'd1;
                    if (w_new_hit) begin
                        r_collected[r_idx] <= 1'b1;
                        r_pulse            <= 1'b1;
                        if (w_is_red) begin
                            if (r_red_count != 2'd3) r_red_count <= r_red_count + 2'd1;
                        end else begin
                            if (r_blue_count != 2'd3) r_blue_count <= r_blue_count + 2'd1;
                        end
                    end
                end
                DONE: begin
                    r_all <= (r_blue_count == 2'd3) && (r_red_count == 2'd3);
                    r_idx <= 3'd0;
                end
                default: r_idx <= 3'd0;
            endcase
        end
    end

`ifdef DIAMOND_SPARKLE_EN
    logic [3:0] r_timer [NUM_DIAMONDS];

    // Timers only count down on accepted frames, so one blink phase spans whole frames.
    always_ff @(posedge Clk) begin
        if (Reset || level_restart) begin
            for (int k = 0; k < NUM_DIAMONDS; k++) r_timer[k] <= 4'd0;
        end else if (w_accept) begin
            for (int k = 0; k < NUM_DIAMONDS; k++) begin
                if (r_timer[k] != 4'd0) r_timer[k] <= r_timer[k] - 4'd1;
            end
        end else if (w_new_hit) begin
            r_timer[r_idx] <= 4'(SPARKLE_FRAMES);
        end
    end

    for (genvar g = 0; g < NUM_DIAMONDS; g++) begin : g_eat_flag
        assign w_eat[g] = (r_timer[g] != 4'd0) ? r_timer[g][1] : r_collected[g];
    end
`else
    for (genvar g = 0; g < NUM_DIAMONDS; g++) begin : g_eat_flag
        assign w_eat[g] = r_collected[g];
    end
`endif

    assign is_diamond_eat_blue = w_eat[2:0];
    assign is_diamond_eat_red  = w_eat[5:3];
    assign blue_count          = r_blue_count;
    assign red_count           = r_red_count;
    assign all_collected       = r_all;
    assign collect_pulse       = r_pulse;
    assign scan_busy           = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_diamond_collect_ctrl.sv
// ============================================================================
// Module  : tb_diamond_collect_ctrl
// Brief   : Directed and random checks of diamond_collect_ctrl against a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_diamond_collect_ctrl;

    logic       Clk = 1'b0;
    logic       Reset, frame_start, game_active, level_restart;
    logic [9:0] fb_x, fb_y, wg_x, wg_y;
    logic [2:0] is_diamond_eat_blue, is_diamond_eat_red;
    logic [1:0] blue_count, red_count;
    logic       all_collected, collect_pulse, scan_busy;

    always #5 Clk = ~Clk;

    diamond_collect_ctrl u_dut (
        .Clk                 (Clk),
        .Reset               (Reset),
        .frame_start         (frame_start),
        .game_active         (game_active),
        .level_restart       (level_restart),
        .fb_x                (fb_x),
        .fb_y                (fb_y),
        .wg_x                (wg_x),
        .wg_y                (wg_y),
        .is_diamond_eat_blue (is_diamond_eat_blue),
        .is_diamond_eat_red  (is_diamond_eat_red),
        .blue_count          (blue_count),
        .red_count           (red_count),
        .all_collected       (all_collected),
        .collect_pulse       (collect_pulse),
        .scan_busy           (scan_busy)
    );

    int dx [6] = '{460, 366, 38, 330, 300, 190};
    int dy [6] = '{408, 238, 90, 408, 220, 42};

    int total = 0;
    int bad   = 0;
    int npulse = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit overlap(input int px, input int py, input int ddx, input int ddy);
        return (px < ddx + 20) && (px + 20 > ddx) && (py < ddy + 20) && (py + 30 > ddy);
    endfunction

    // Frame-level model: a scan starts on an accepted frame and diamond k resolves
    // k+1 clocks later; the level status settles 7 clocks after the frame.
    int       cyc = 0;
    bit       m_active = 1'b0;
    int       m_start = 0;
    int       s_fx, s_fy, s_wx, s_wy;
    bit [5:0] m_coll = '0;
    int       m_bc = 0, m_rc = 0;
    bit       m_all = 1'b0, m_pulse = 1'b0;

    always @(posedge Clk) begin
        int  k, px, py;
        bit  was_busy;
        cyc++;
        if (Reset || level_restart) begin
            m_active = 1'b0; m_coll = '0; m_bc = 0; m_rc = 0; m_all = 1'b0; m_pulse = 1'b0;
        end else begin
            m_pulse  = 1'b0;
            was_busy = m_active;
            if (m_active) begin
                k = cyc - m_start - 1;
                if (k >= 0 && k < 6) begin
                    px = (k < 3) ? s_wx : s_fx;
                    py = (k < 3) ? s_wy : s_fy;
                    if (overlap(px, py, dx[k], dy[k]) && !m_coll[k]) begin
                        m_coll[k] = 1'b1;
                        m_pulse   = 1'b1;
                        if (k < 3) m_bc = (m_bc < 3) ? m_bc + 1 : 3;
                        else       m_rc = (m_rc < 3) ? m_rc + 1 : 3;
                    end
                end else if (k == 6) begin
                    m_all    = (m_bc == 3) && (m_rc == 3);
                    m_active = 1'b0;
                end
            end
            if (!was_busy && frame_start && game_active) begin
                m_active = 1'b1;
                m_start  = cyc;
                s_fx = int'(fb_x); s_fy = int'(fb_y);
                s_wx = int'(wg_x); s_wy = int'(wg_y);
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("model eat_blue", 32'(is_diamond_eat_blue), 32'(m_coll[2:0]));
            check("model eat_red",  32'(is_diamond_eat_red),  32'(m_coll[5:3]));
            check("model blue_count", 32'(blue_count), 32'(m_bc));
            check("model red_count",  32'(red_count),  32'(m_rc));
            check("model all_collected", 32'(all_collected), 32'(m_all));
            check("model collect_pulse", 32'(collect_pulse), 32'(m_pulse));
            check("model scan_busy", 32'(scan_busy), 32'(m_active));
            if (collect_pulse === 1'b1) npulse++;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Drives a one-cycle frame_start; returns one cycle after it (T+1).
    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic rand_pos(output logic [9:0] x, output logic [9:0] y);
        int j;
        if ($urandom_range(0, 1) == 0) begin
            j = int'($urandom_range(0, 5));
            x = 10'(dx[j] - 22 + int'($urandom_range(0, 44)));
            y = 10'(dy[j] - 32 + int'($urandom_range(0, 54)));
        end else begin
            x = 10'($urandom_range(0, 1023));
            y = 10'($urandom_range(0, 1023));
        end
    endtask

    initial begin
        int p0;
        Reset = 1'b1; frame_start = 1'b0; game_active = 1'b1; level_restart = 1'b0;
        fb_x = 10'd1000; fb_y = 10'd1000; wg_x = 10'd1000; wg_y = 10'd1000;
        step();
        chk_en = 1'b1;
        steps(2);
        check("reset flags", 32'({is_diamond_eat_red, is_diamond_eat_blue}), 32'd0);
        check("reset busy",  32'(scan_busy), 32'd0);
        Reset = 1'b0;
        step();

        // Blue 0 taken by watergirl on the first scan slot.
        wg_x = 10'd455; wg_y = 10'd400;
        frame();
        check("t1 busy T+1", 32'(scan_busy), 32'd1);
        step();
        check("t1 eat_blue T+2", 32'(is_diamond_eat_blue), 32'b001);
        check("t1 blue_count", 32'(blue_count), 32'd1);
        check("t1 pulse T+2", 32'(collect_pulse), 32'd1);
        step();
        check("t1 pulse T+3", 32'(collect_pulse), 32'd0);
        steps(6);

        // Edge touching red 0 is not a hit; one pixel further left is.
        fb_x = 10'd350; fb_y = 10'd408;
        frame();
        steps(7);
        check("t2 edge no hit", 32'(is_diamond_eat_red), 32'd0);
        fb_x = 10'd349;
        frame();
        steps(3);
        check("t2 red T+4", 32'(is_diamond_eat_red), 32'd0);
        step();
        check("t2 red T+5", 32'(is_diamond_eat_red), 32'b001);
        check("t2 red_count", 32'(red_count), 32'd1);
        steps(4);

        // Standing on already-collected diamonds produces nothing new.
        p0 = npulse;
        repeat (3) begin
            frame();
            steps(8);
        end
        check("t3 blue_count", 32'(blue_count), 32'd1);
        check("t3 no pulses", 32'(npulse - p0), 32'd0);

        // Collect the remaining four.
        wg_x = 10'(dx[1]); wg_y = 10'(dy[1]); fb_x = 10'(dx[4]); fb_y = 10'(dy[4]);
        frame();
        steps(8);
        wg_x = 10'(dx[2]); wg_y = 10'(dy[2]); fb_x = 10'(dx[5]); fb_y = 10'(dy[5]);
        frame();
        steps(6);
        check("t4 all T+7", 32'(all_collected), 32'd0);
        step();
        check("t4 all T+8", 32'(all_collected), 32'd1);
        check("t4 counts", 32'({blue_count, red_count}), 32'b1111);
        steps(2);
        level_restart = 1'b1;
        step();
        level_restart = 1'b0;
        check("t4 restart flags", 32'({is_diamond_eat_red, is_diamond_eat_blue}), 32'd0);
        check("t4 restart counts", 32'({blue_count, red_count, all_collected}), 32'd0);

        // Restart mid-scan before red 1 resolves; a same-cycle frame is dropped.
        wg_x = 10'd1000; wg_y = 10'd1000; fb_x = 10'(dx[4]); fb_y = 10'(dy[4]);
        frame();
        step();
        level_restart = 1'b1; frame_start = 1'b1;
        step();
        level_restart = 1'b0; frame_start = 1'b0;
        check("t5 busy after restart", 32'(scan_busy), 32'd0);
        steps(7);
        check("t5 red flags", 32'(is_diamond_eat_red), 32'd0);

        // A frame during SCAN must not extend the scan.
        frame();
        step();
        frame();
        steps(4);
        check("t5 busy T+7", 32'(scan_busy), 32'd1);
        step();
        check("t5 busy T+8", 32'(scan_busy), 32'd0);
        check("t5 red1 taken", 32'(is_diamond_eat_red), 32'b010);

        level_restart = 1'b1;
        step();
        level_restart = 1'b0;

        for (int n = 0; n < 1500; n++) begin
            frame_start   = ($urandom_range(0, 3) == 0);
            game_active   = ($urandom_range(0, 7) != 0);
            level_restart = ($urandom_range(0, 149) == 0);
            rand_pos(fb_x, fb_y);
            rand_pos(wg_x, wg_y);
            step();
        end
        frame_start = 1'b0; level_restart = 1'b0;
        steps(10);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
